// File: rtl/order_translate_gen.sv
// Order-to-address translator: N_CH order indices per beat become a bank index
// (digit sum or XOR fold) and a memory address (order >> DELTA) through an N_DIGITS-deep pipeline.
module order_translate_gen #(
  parameter int D_WIDTH  = 32,
  parameter int DIGIT_W  = 4,
  parameter int N_DIGITS = 4,
  parameter int DELTA    = 4,
  parameter int MA_WIDTH = 12,
  parameter int N_CH     = 2,
  parameter int L_WIDTH  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*D_WIDTH-1:0]  order_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     bank_mode,
  input  logic                     done_in,
  input  logic [L_WIDTH-1:0]       l_in,
  output logic [N_CH*MA_WIDTH-1:0] ma_out,
  output logic [N_CH*DIGIT_W-1:0]  bn_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done_out,
  output logic [L_WIDTH-1:0]       l_out,
  output logic [15:0]              xfer_cnt
);

  localparam int LAST = N_DIGITS - 1;

  logic               valid_reg [N_DIGITS];
  logic               mode_reg  [N_DIGITS];
  logic               done_reg  [N_DIGITS];
  logic [L_WIDTH-1:0] l_reg     [N_DIGITS];
  logic [D_WIDTH-1:0] order_reg [N_DIGITS][N_CH];
  logic [DIGIT_W-1:0] acc_reg   [N_DIGITS][N_CH];
  logic [15:0]        cnt_reg;
  logic               stall;

  function automatic logic [DIGIT_W-1:0] fold(input logic [DIGIT_W-1:0] acc,
                                               input logic [DIGIT_W-1:0] digit,
                                               input logic               xor_mode);
    // Add carry falls off the DIGIT_W-bit result, giving the mod-radix sum.
    return xor_mode ? (acc ^ digit) : (acc + digit);
  endfunction

  assign stall    = valid_reg[LAST] && !out_ready;
  assign in_ready = !stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < N_DIGITS; s++) begin
        valid_reg[s] <= 1'b0;
        mode_reg[s]  <= 1'b0;
        done_reg[s]  <= 1'b0;
        l_reg[s]     <= '0;
        for (int c = 0; c < N_CH; c++) begin
          order_reg[s][c] <= '0;
          acc_reg[s][c]   <= '0;
        end
      end
      cnt_reg <= '0;
    end else begin
      if (!stall) begin
        valid_reg[0] <= in_valid;
        mode_reg[0]  <= bank_mode;
        done_reg[0]  <= done_in;
        l_reg[0]     <= l_in;
        for (int c = 0; c < N_CH; c++) begin
          order_reg[0][c] <= order_in[c*D_WIDTH +: D_WIDTH];
          acc_reg[0][c]   <= order_in[c*D_WIDTH +: DIGIT_W];
        end
        for (int s = 1; s < N_DIGITS; s++) begin
          valid_reg[s] <= valid_reg[s-1];
          mode_reg[s]  <= mode_reg[s-1];
          done_reg[s]  <= done_reg[s-1];
          l_reg[s]     <= l_reg[s-1];
          for (int c = 0; c < N_CH; c++) begin
            order_reg[s][c] <= order_reg[s-1][c];
            acc_reg[s][c]   <= fold(acc_reg[s-1][c],
                                    order_reg[s-1][c][s*DIGIT_W +: DIGIT_W],
                                    mode_reg[s-1]);
          end
        end
      end
      if (valid_reg[LAST] && out_ready) begin
        cnt_reg <= done_reg[LAST] ? 16'd0 : cnt_reg + 16'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      // Zero-extend before shifting so a wide MA_WIDTH reads zeros past the order's MSB.
      assign ma_out[gi*MA_WIDTH +: MA_WIDTH] = valid_reg[LAST]
          ? MA_WIDTH'({{MA_WIDTH{1'b0}}, order_reg[LAST][gi]} >> DELTA) : '0;
      assign bn_out[gi*DIGIT_W +: DIGIT_W] = valid_reg[LAST] ? acc_reg[LAST][gi] : '0;
    end
  endgenerate

  assign out_valid = valid_reg[LAST];
  assign done_out  = valid_reg[LAST] && done_reg[LAST];
  assign l_out     = valid_reg[LAST] ? l_reg[LAST] : '0;
  assign xfer_cnt  = cnt_reg;

endmodule

// File: doc/order_translate_gen.md
# order_translate_gen

Parametrised order-to-address translator for the NTT address-generation path. It sits between the AGU and the memory-bank arbiter. It converts N_CH order indices per beat into a bank index and a memory address:
- Bank index: a modular digit sum or XOR fold of the radix digits, selectable per beat.
- Memory address: the order index shifted right by DELTA.

It generalises the fixed 2-channel, 4-digit translator with parametrised width, digit count and channel count, a per-beat bank mode, valid/ready back-pressure and a transfer counter.

## Interface
Parameters:
- D_WIDTH, 32, order index width
- DIGIT_W, 4, bits per radix digit (radix = 2^DIGIT_W); bank index width equals DIGIT_W
- N_DIGITS, 4, digits folded into the bank index (N_DIGITS*DIGIT_W <= D_WIDTH, N_DIGITS >= 2)
- DELTA, 4, right shift applied to form the memory address
- MA_WIDTH, 12, memory address width
- N_CH, 2, parallel channels
- L_WIDTH, 3, stage tag width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- order_in  in  N_CH*D_WIDTH  channel c at bits [c*D_WIDTH +: D_WIDTH]
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- bank_mode  in  1  0 = sum of digits mod 2^DIGIT_W, 1 = XOR of digits; sampled with the beat
- done_in  in  1  last-beat marker, sampled with the beat
- l_in  in  L_WIDTH  stage tag, sampled with the beat
- ma_out  out  N_CH*MA_WIDTH  memory address per channel
- bn_out  out  N_CH*DIGIT_W  bank index per channel
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts
- done_out  out  1  done_in of the current output beat
- l_out  out  L_WIDTH  tag of the current output beat
- xfer_cnt  out  16  accepted output beats since reset or last done

## Operation
- Pipeline of N_DIGITS register stages:
  - Stage 0 registers the order, mode, tag, done and valid, and splits the digits.
  - Stages 1..N_DIGITS-2 each fold one further digit into a DIGIT_W-bit accumulator: mod-2^DIGIT_W add, or XOR, per the carried mode.
  - The final stage folds the last digit and registers the outputs.
- Width rules:
  - Accumulator is exactly DIGIT_W bits; the add carry is discarded, which is mod radix.
  - ma = (order >> DELTA)[MA_WIDTH-1:0], zero-filled if MA_WIDTH exceeds the remaining bits.
  - Order bits above N_DIGITS*DIGIT_W do not affect bn.
- Channels are independent datapaths and share the valid, mode, tag and done of the beat.
- Stall rule:
  - stall = out_valid && !out_ready.
  - While stalled, every pipeline register, including valid bits, holds.
  - in_ready = !stall, combinational.
  - Bubbles (valid=0) advance and are overwritten when not stalled.
- Output gating: when out_valid=0, ma_out, bn_out, done_out and l_out read 0.
- xfer_cnt:
  - Increments on each out_valid && out_ready.
  - On a transfer with done_out=1 it loads 0 instead of incrementing.
  - Wraps 0xFFFF -> 0.
- Reset (rst low, any time including mid-stream):
  - All valid bits, data registers and xfer_cnt go to 0 immediately.
  - All outputs read 0; in_ready reads 1.
  - In-flight beats are discarded.

## Timing
- Latency: a beat accepted on edge k appears at the outputs after edge k+N_DIGITS-1, i.e. N_DIGITS cycles from presentation (4 with the defaults).
- Throughput: one beat per cycle with out_ready held high.
- A stall holds out_valid and the data stable until the transfer edge; no beat is dropped or duplicated.
- Simultaneous events:
  - When out_ready rises in the same cycle as in_valid, the input is accepted that cycle.
  - A done transfer and a normal increment never coincide; done wins and xfer_cnt loads 0.
- No combinational path from inputs to data outputs; in_ready depends only on out_valid and out_ready.

## Test plan
- Defaults, mode 0, order_in ch0=0x1234, ch1=0xFFFF, out_ready=1:
  - After 4 cycles: ma ch0=0x123, bn ch0=0xA; ma ch1=0xFFF, bn ch1=0xC.
  - out_valid is 1 for one cycle.
- Same orders, mode 1: bn ch0=0x4, ch1=0x0; ma unchanged.
- Streaming and stall:
  - Stream 8 back-to-back beats with orders 0..7; drop out_ready for cycles 5-7.
  - in_ready is low while stalled; outputs hold.
  - All 8 beats emerge in order with bn = order mod 16; xfer_cnt reaches 8.
- Done and tag:
  - Beat 3 of 4 carries done_in=1, l_in=5.
  - done_out=1 and l_out=5 with that beat; xfer_cnt reads 0 after its transfer, then 1 after beat 4.
- Reset mid-stream:
  - Pull rst low with 3 beats in flight and during a stall.
  - All outputs read 0 and in_ready reads 1 immediately.
  - After release, no stale beat emerges.
- N_CH=4, N_DIGITS=6, DIGIT_W=3: order 0o654321 mode 0 gives bn = 21 mod 8 = 5, checked on every channel.
